// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock parametrised FIFO with fill count, programmable
// almost-full / almost-empty thresholds, sticky overflow / underflow
// flags and a synchronous clear.
//
// Build option:
//   SYNC_FIFO_PARAM_FWFT_EN  defined   -> first-word-fall-through read
//                            undefined -> registered read, 1-cycle latency
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-low reset
//   clr       synchronous clear (empties FIFO, clears sticky flags)
//   wr_en     write request
//   data_in   write data
//   rd_en     read request (pop acknowledge in FWFT mode)
//   data_out  read data
//   f_full    count == ADDRDEPTH
//   f_empty   count == 0
//   f_afull   count >= AFULL_TH
//   f_aempty  count <= AEMPTY_TH
//   count     occupancy, 0..ADDRDEPTH
//   f_ovf     sticky: write attempted while full
//   f_udf     sticky: read attempted while empty
module sync_fifo_param #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4,
    parameter int ADDRDEPTH = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [DATAWIDTH-1:0] data_in,
    input  logic                 rd_en,
    output logic [DATAWIDTH-1:0] data_out,
    output logic                 f_full,
    output logic                 f_empty,
    output logic                 f_afull,
    output logic                 f_aempty,
    output logic [ADDRWIDTH:0]   count,
    output logic                 f_ovf,
    output logic                 f_udf
);

    localparam int PW = ADDRWIDTH + 1;
    localparam logic [ADDRWIDTH:0] PTR_ONE  = PW'(1);
    localparam logic [ADDRWIDTH:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [ADDRWIDTH:0] AEMPTY_C = PW'(AEMPTY_TH);

    if (ADDRDEPTH != (1 << ADDRWIDTH)) begin : g_depth_chk
        $error("sync_fifo_param: ADDRDEPTH must equal 2**ADDRWIDTH");
    end
    if (!(AEMPTY_TH >= 0 && AEMPTY_TH < AFULL_TH && AFULL_TH <= ADDRDEPTH)) begin : g_th_chk
        $error("sync_fifo_param: thresholds must satisfy 0 <= AEMPTY_TH < AFULL_TH <= ADDRDEPTH");
    end

    logic [DATAWIDTH-1:0] mem [ADDRDEPTH];

    logic [ADDRWIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTH:0] rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               wr_acc;
    logic               rd_acc;

    // Flags depend only on registered pointers, so there is no
    // combinational path from any input to any output.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign f_empty  = (wr_ptr_q == rd_ptr_q);
    assign f_full   = (wr_ptr_q[ADDRWIDTH] != rd_ptr_q[ADDRWIDTH]) &&
                      (wr_ptr_q[ADDRWIDTH-1:0] == rd_ptr_q[ADDRWIDTH-1:0]);
    assign f_afull  = (count >= AFULL_C);
    assign f_aempty = (count <= AEMPTY_C);
    assign f_ovf    = ovf_q;
    assign f_udf    = udf_q;

    assign wr_acc = wr_en && !f_full;
    assign rd_acc = rd_en && !f_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            ovf_d = ovf_q | (wr_en & f_full);
            udf_d = udf_q | (rd_en & f_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage has no reset; a write in a reset or clear cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst && !clr && wr_acc) begin
            mem[wr_ptr_q[ADDRWIDTH-1:0]] <= data_in;
        end
    end

`ifdef SYNC_FIFO_PARAM_FWFT_EN
    // Head word is presented directly; zero when nothing is stored.
    assign data_out = f_empty ? '0 : mem[rd_ptr_q[ADDRWIDTH-1:0]];
`else
    logic [DATAWIDTH-1:0] dout_q;

    // Clear leaves the last read word in place; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (!clr && rd_acc) begin
            dout_q <= mem[rd_ptr_q[ADDRWIDTH-1:0]];
        end
    end

    assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int DEP = 16;
    localparam int AFT = 12;
    localparam int AET = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [AW:0]   count;

    sync_fifo_param #(
        .DATAWIDTH(DW), .ADDRWIDTH(AW), .ADDRDEPTH(DEP),
        .AFULL_TH(AFT), .AEMPTY_TH(AET)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out),
        .f_full(f_full), .f_empty(f_empty),
        .f_afull(f_afull), .f_aempty(f_aempty),
        .count(count), .f_ovf(f_ovf), .f_udf(f_udf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: a queue of stored words plus sticky bits and the
    // last-popped word for the registered-read mode.
    logic [DW-1:0] q_model[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic [DW-1:0] m_dout = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r_n, input logic c, input logic w,
                              input logic r, input logic [DW-1:0] d);
        logic was_full, was_empty;
        was_full  = (q_model.size() == DEP);
        was_empty = (q_model.size() == 0);
        if (!r_n) begin
            q_model.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_dout = '0;
        end else if (c) begin
            q_model.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) m_dout = q_model.pop_front();
            if (w && !was_full)  q_model.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        logic [DW-1:0] exp_dout;
        n = q_model.size();
`ifdef SYNC_FIFO_PARAM_FWFT_EN
        exp_dout = (n == 0) ? '0 : q_model[0];
`else
        exp_dout = m_dout;
`endif
        chk("count",    32'(count),    32'(n));
        chk("f_empty",  32'(f_empty),  32'(n == 0));
        chk("f_full",   32'(f_full),   32'(n == DEP));
        chk("f_afull",  32'(f_afull),  32'(n >= AFT));
        chk("f_aempty", 32'(f_aempty), 32'(n <= AET));
        chk("f_ovf",    32'(f_ovf),    32'(m_ovf));
        chk("f_udf",    32'(f_udf),    32'(m_udf));
        chk("data_out", 32'(data_out), 32'(exp_dout));
    endtask

    task automatic cyc(input logic r_n, input logic c, input logic w,
                       input logic r, input logic [DW-1:0] d);
        @(negedge clk);
        rst = r_n; clr = c; wr_en = w; rd_en = r; data_in = d;
        @(posedge clk);
        model_step(r_n, c, w, r, d);
        #1;
        check_all();
    endtask

    initial begin
        int v;
        // reset
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_dout",  32'(data_out), 32'd0);

        // fill 1..16, then write 17 while full
        for (int i = 1; i <= 17; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, DW'(i));
        chk("fill_full", 32'(f_full), 32'd1);
        chk("fill_ovf",  32'(f_ovf),  32'd1);

        // drain 16, then read once more while empty
        for (int i = 1; i <= 17; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);
        chk("drain_udf", 32'(f_udf), 32'd1);

        // build to 8, then 20 cycles of simultaneous traffic
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, DW'(8'h40 + i));
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, DW'(8'h48 + i));
        chk("simul_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // full with both requests: read wins, write rejected
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, DW'(8'h80 + i));
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hEE);
        chk("full_both_count", 32'(count), 32'd15);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // empty with both requests: write wins, read rejected
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
        chk("empty_both_count", 32'(count), 32'd1);
        chk("empty_both_udf",   32'(f_udf), 32'd1);

        // count 10 with f_ovf, then clr with wr_en
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, DW'(8'hA0 + i));
        for (int i = 0; i < 6; i++)  cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);
        chk("pre_clr_count", 32'(count), 32'd10);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hCC);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_ovf",   32'(f_ovf),  32'd0);

        // same scenario with reset instead of clear
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, DW'(8'hB0 + i));
        for (int i = 0; i < 7; i++)  cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hDD);
        chk("rst_count", 32'(count),    32'd0);
        chk("rst_dout",  32'(data_out), 32'd0);

        // randomized traffic with occasional clear / reset
        for (int i = 0; i < 3000; i++) begin
            logic w, r, c, rn;
            v  = int'($urandom_range(0, 99));
            w  = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 70 : 35));
            r  = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 35 : 70));
            c  = (v == 0);
            rn = !(v == 1);
            cyc(rn, c, w, r, DW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
